// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the multi-lane Mandelbrot sequencer.
//   - fsm_state_t  : frame sequencer states
//   - lane_state_t : per-lane iteration states
//   - ctr_sel_t    : counter-to-colour mapping selects
//   - lane_idx_w() : width of a lane index for a given lane count
//   - ctr_map()    : iteration count -> 4-bit colour index
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_t;

  typedef enum logic [1:0] {
    LANE_FREE = 2'd0,
    LANE_ITER = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_t;

  // Selects 0..6 take a 4-bit slice of the counter; 7 takes the MSB index.
  typedef enum logic [2:0] {
    SEL_SLICE0 = 3'd0,
    SEL_SLICE1 = 3'd1,
    SEL_SLICE2 = 3'd2,
    SEL_SLICE3 = 3'd3,
    SEL_SLICE4 = 3'd4,
    SEL_SLICE5 = 3'd5,
    SEL_SLICE6 = 3'd6,
    SEL_MSB    = 3'd7
  } ctr_sel_t;

  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // ctr is zero-extended to 16 bits; ctr_width is the real counter width.
  function automatic logic [3:0] ctr_map(input logic [15:0] ctr,
                                         input logic [2:0]  sel,
                                         input int          ctr_width);
    logic [15:0] mask;
    logic [3:0]  res;
    int          sh;
    res  = 4'd0;
    mask = 16'((32'd1 << ctr_width) - 32'd1);
    sh   = 2 * int'(sel);
    if (sel == SEL_MSB) begin
      // A saturated counter gets its own colour (15) rather than its MSB index.
      if ((ctr & mask) == mask) begin
        res = 4'd15;
      end else begin
        for (int b = 0; b < 16; b++) begin
          if (ctr[b]) res = 4'(b);
        end
      end
    end else begin
      if (sh > ctr_width - 4) sh = ctr_width - 4;
      res = 4'(ctr >> sh);
    end
    return res;
  endfunction

endpackage

// File: rtl/mandelbrot_lane.sv
// One iteration lane plus its combinational complex-square ALU.
// Fixed point: signed Q3.(BITWIDTH-3), i.e. range [-4, 4).
//
// mandelbrot_alu ports:
//   i_zr/i_zi/i_cr/i_ci  current z and c
//   o_zr/o_zi            z^2 + c (truncated to BITWIDTH)
//   o_escape             |z|^2 >= 4 (evaluated on the current z)
//   o_overflow           z^2 + c does not fit in BITWIDTH
//
// mandelbrot_lane ports:
//   clk, rst_n           clock, async active-low reset
//   i_clear              synchronous abort: lane becomes free
//   i_start              dispatch a pixel (honoured only when free)
//   i_cr/i_ci/i_zr0/i_zi0 pixel constant and starting z
//   i_max_ctr            iteration limit
//   i_retire             result consumed; lane is free next cycle
//   o_free/o_done/o_ctr  lane status and held iteration count
module mandelbrot_alu #(
  parameter int BITWIDTH = 10
) (
  input  logic signed [BITWIDTH-1:0] i_zr,
  input  logic signed [BITWIDTH-1:0] i_zi,
  input  logic signed [BITWIDTH-1:0] i_cr,
  input  logic signed [BITWIDTH-1:0] i_ci,
  output logic signed [BITWIDTH-1:0] o_zr,
  output logic signed [BITWIDTH-1:0] o_zi,
  output logic                       o_escape,
  output logic                       o_overflow
);
  localparam int FRAC = BITWIDTH - 3;
  localparam int PW   = 2 * BITWIDTH + 2;
  localparam logic signed [PW-1:0] ESC_THR = PW'(1) << (2 * FRAC + 2);
  localparam logic signed [PW-1:0] MAXV    = PW'((1 << (BITWIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] MINV    = ~MAXV;

  logic signed [PW-1:0] w_zr, w_zi, w_cr, w_ci;
  logic signed [PW-1:0] w_zr2, w_zi2, w_zrzi, w_mag, w_nr, w_ni;

  assign w_zr   = PW'(i_zr);
  assign w_zi   = PW'(i_zi);
  assign w_cr   = PW'(i_cr);
  assign w_ci   = PW'(i_ci);
  assign w_zr2  = w_zr * w_zr;
  assign w_zi2  = w_zi * w_zi;
  assign w_zrzi = w_zr * w_zi;
  // Magnitude is compared at full product precision, so no rounding enters it.
  assign w_mag  = w_zr2 + w_zi2;
  assign w_nr   = ((w_zr2 - w_zi2) >>> FRAC) + w_cr;
  assign w_ni   = ((w_zrzi <<< 1) >>> FRAC) + w_ci;

  assign o_escape   = (w_mag >= ESC_THR);
  assign o_overflow = (w_nr > MAXV) || (w_nr < MINV) || (w_ni > MAXV) || (w_ni < MINV);
  assign o_zr       = w_nr[BITWIDTH-1:0];
  assign o_zi       = w_ni[BITWIDTH-1:0];
endmodule

module mandelbrot_lane
  import mandelbrot_pkg::*;
#(
  parameter int BITWIDTH = 10,
  parameter int CTRWIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_start,
  input  logic signed [BITWIDTH-1:0] i_cr,
  input  logic signed [BITWIDTH-1:0] i_ci,
  input  logic signed [BITWIDTH-1:0] i_zr0,
  input  logic signed [BITWIDTH-1:0] i_zi0,
  input  logic        [CTRWIDTH-1:0] i_max_ctr,
  input  logic                       i_retire,
  output logic                       o_free,
  output logic                       o_done,
  output logic        [CTRWIDTH-1:0] o_ctr
);
  lane_state_t r_state, w_state_nxt;
  logic signed [BITWIDTH-1:0] r_zr, r_zi, r_cr, r_ci, w_nr, w_ni;
  logic        [CTRWIDTH-1:0] r_ctr;
  logic                       w_escape, w_overflow, w_break;

  mandelbrot_alu #(.BITWIDTH(BITWIDTH)) u_alu (
    .i_zr       (r_zr),
    .i_zi       (r_zi),
    .i_cr       (r_cr),
    .i_ci       (r_ci),
    .o_zr       (w_nr),
    .o_zi       (w_ni),
    .o_escape   (w_escape),
    .o_overflow (w_overflow)
  );

  // Every ITER cycle is one ALU pass; the limit check makes max_ctr=0 a single pass.
  assign w_break = w_escape || w_overflow || (r_ctr == i_max_ctr);

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      LANE_FREE: if (i_start)  w_state_nxt = LANE_ITER;
      LANE_ITER: if (w_break)  w_state_nxt = LANE_DONE;
      LANE_DONE: if (i_retire) w_state_nxt = LANE_FREE;
      default:                 w_state_nxt = LANE_FREE;
    endcase
    if (i_clear) w_state_nxt = LANE_FREE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (!rst_n) r_state <= LANE_FREE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zr  <= '0;
      r_zi  <= '0;
      r_cr  <= '0;
      r_ci  <= '0;
      r_ctr <= '0;
    end else if (r_state == LANE_FREE && i_start) begin
      r_zr  <= i_zr0;
      r_zi  <= i_zi0;
      r_cr  <= i_cr;
      r_ci  <= i_ci;
      r_ctr <= '0;
    end else if (r_state == LANE_ITER && !w_break) begin
      r_zr  <= w_nr;
      r_zi  <= w_ni;
      r_ctr <= r_ctr + 1'b1;
    end
  end

  assign o_free = (r_state == LANE_FREE);
  assign o_done = (r_state == LANE_DONE);
  assign o_ctr  = r_ctr;
endmodule

// File: rtl/mandelbrot_multilane.sv
// Raster-order Mandelbrot frame sequencer with LANES parallel iteration lanes.
// Pixels are dispatched round-robin to lanes and retired round-robin, so the
// output stream is always in raster order. Configuration is latched on run.
// Optional feature: define MANDEL_JULIA_EN to add julia/jc_r/jc_i inputs;
// with julia=1 the lanes use c=(jc_r,jc_i) and z0=pixel coordinate.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   run                   start a frame (sampled only in IDLE)
//   abort                 synchronous abort, any state
//   busy                  high unless IDLE
//   max_ctr               iteration limit
//   ctr_select            counter-to-colour mapping
//   scaling               step = scaling+1 LSBs per pixel/row
//   cr_offset/ci_offset   frame origin
//   julia, jc_r, jc_i     Julia mode controls (MANDEL_JULIA_EN only)
//   pix_valid/pix_ready   output pixel handshake
//   pix_ctr               colour index
//   pix_x/pix_y           pixel coordinates
//   pix_last              last pixel of the frame
module mandelbrot_multilane
  import mandelbrot_pkg::*;
#(
  parameter int BITWIDTH = 10,
  parameter int CTRWIDTH = 7,
  parameter int HEIGHT   = 240,
  parameter int WIDTH    = 320,
  parameter int LANES    = 2,
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                abort,
  output logic                busy,
  input  logic [CTRWIDTH-1:0] max_ctr,
  input  logic [2:0]          ctr_select,
  input  logic [6:0]          scaling,
  input  logic [BITWIDTH-1:0] cr_offset,
  input  logic [BITWIDTH-1:0] ci_offset,
`ifdef MANDEL_JULIA_EN
  input  logic                julia,
  input  logic [BITWIDTH-1:0] jc_r,
  input  logic [BITWIDTH-1:0] jc_i,
`endif
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [3:0]          pix_ctr,
  output logic [XW-1:0]       pix_x,
  output logic [YW-1:0]       pix_y,
  output logic                pix_last
);
  localparam int LW = lane_idx_w(LANES);

  fsm_state_t r_state, w_state_nxt;

  // Latched configuration
  logic [CTRWIDTH-1:0] r_max_ctr;
  logic [2:0]          r_sel;
  logic [BITWIDTH-1:0] r_step, r_cr_off;

  // Dispatch side
  logic [XW-1:0]       r_dx;
  logic [YW-1:0]       r_dy;
  logic [BITWIDTH-1:0] r_cr, r_ci;
  logic [LW-1:0]       r_dptr;

  // Retire side
  logic [XW-1:0]       r_rx;
  logic [YW-1:0]       r_ry;
  logic [LW-1:0]       r_rptr;

  // Output register
  logic                r_pix_valid, r_pix_last;
  logic [3:0]          r_pix_ctr;
  logic [XW-1:0]       r_pix_x;
  logic [YW-1:0]       r_pix_y;

  logic [LANES-1:0]    w_lane_free, w_lane_done;
  logic [CTRWIDTH-1:0] w_lane_ctr [LANES];
  logic [BITWIDTH-1:0] w_lane_cr, w_lane_ci, w_lane_zr0, w_lane_zi0;
  logic                w_launch, w_dispatch, w_accept, w_load;
  logic                w_dx_end, w_d_last, w_rx_end;

  assign w_launch   = (r_state == ST_IDLE) && run && !abort;
  assign w_dispatch = (r_state == ST_RUN) && !abort && w_lane_free[r_dptr];
  assign w_accept   = r_pix_valid && pix_ready;
  assign w_load     = !r_pix_valid && (r_state != ST_IDLE) && w_lane_done[r_rptr];
  assign w_dx_end   = (r_dx == XW'(WIDTH - 1));
  assign w_d_last   = w_dx_end && (r_dy == YW'(HEIGHT - 1));
  assign w_rx_end   = (r_rx == XW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (run)                       w_state_nxt = ST_RUN;
      ST_RUN:   if (w_dispatch && w_d_last)    w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_accept && r_pix_last)    w_state_nxt = ST_IDLE;
      default:                                 w_state_nxt = ST_IDLE;
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

`ifdef MANDEL_JULIA_EN
  logic                r_julia;
  logic [BITWIDTH-1:0] r_jc_r, r_jc_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_julia <= 1'b0;
      r_jc_r  <= '0;
      r_jc_i  <= '0;
    end else if (w_launch) begin
      r_julia <= julia;
      r_jc_r  <= jc_r;
      r_jc_i  <= jc_i;
    end
  end

  assign w_lane_cr  = r_julia ? r_jc_r : r_cr;
  assign w_lane_ci  = r_julia ? r_jc_i : r_ci;
  assign w_lane_zr0 = r_julia ? r_cr   : '0;
  assign w_lane_zi0 = r_julia ? r_ci   : '0;
`else
  assign w_lane_cr  = r_cr;
  assign w_lane_ci  = r_ci;
  assign w_lane_zr0 = '0;
  assign w_lane_zi0 = '0;
`endif

  // Dispatch and retire pointers/coordinates. Retire coordinates are tracked
  // separately because retirement order equals dispatch order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_ctr <= '0;
      r_sel     <= '0;
      r_step    <= '0;
      r_cr_off  <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_cr      <= '0;
      r_ci      <= '0;
      r_dptr    <= '0;
      r_rx      <= '0;
      r_ry      <= '0;
      r_rptr    <= '0;
    end else if (w_launch) begin
      r_max_ctr <= max_ctr;
      r_sel     <= ctr_select;
      r_step    <= BITWIDTH'(scaling) + BITWIDTH'(1);
      r_cr_off  <= cr_offset;
      r_dx      <= '0;
      r_dy      <= '0;
      r_cr      <= cr_offset;
      r_ci      <= ci_offset;
      r_dptr    <= '0;
      r_rx      <= '0;
      r_ry      <= '0;
      r_rptr    <= '0;
    end else begin
      if (w_dispatch) begin
        r_dptr <= (r_dptr == LW'(LANES - 1)) ? '0 : r_dptr + 1'b1;
        if (w_dx_end) begin
          r_dx <= '0;
          r_dy <= r_dy + 1'b1;
          r_cr <= r_cr_off;
          r_ci <= r_ci + r_step;
        end else begin
          r_dx <= r_dx + 1'b1;
          r_cr <= r_cr + r_step;
        end
      end
      if (w_accept) begin
        r_rptr <= (r_rptr == LW'(LANES - 1)) ? '0 : r_rptr + 1'b1;
        if (w_rx_end) begin
          r_rx <= '0;
          r_ry <= r_ry + 1'b1;
        end else begin
          r_rx <= r_rx + 1'b1;
        end
      end
    end
  end

  // The lane keeps its result until the consumer accepts it, so pixels in
  // flight never exceed LANES and backpressure stalls dispatch naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_valid <= 1'b0;
      r_pix_ctr   <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_last  <= 1'b0;
    end else if (abort) begin
      r_pix_valid <= 1'b0;
      r_pix_ctr   <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_last  <= 1'b0;
    end else if (w_accept) begin
      r_pix_valid <= 1'b0;
    end else if (w_load) begin
      r_pix_valid <= 1'b1;
      r_pix_ctr   <= ctr_map(16'(w_lane_ctr[r_rptr]), r_sel, CTRWIDTH);
      r_pix_x     <= r_rx;
      r_pix_y     <= r_ry;
      r_pix_last  <= w_rx_end && (r_ry == YW'(HEIGHT - 1));
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mandelbrot_lane #(.BITWIDTH(BITWIDTH), .CTRWIDTH(CTRWIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (abort),
      .i_start   (w_dispatch && (r_dptr == LW'(g))),
      .i_cr      (w_lane_cr),
      .i_ci      (w_lane_ci),
      .i_zr0     (w_lane_zr0),
      .i_zi0     (w_lane_zi0),
      .i_max_ctr (r_max_ctr),
      .i_retire  (w_accept && (r_rptr == LW'(g))),
      .o_free    (w_lane_free[g]),
      .o_done    (w_lane_done[g]),
      .o_ctr     (w_lane_ctr[g])
    );
  end

  assign busy      = (r_state != ST_IDLE);
  assign pix_valid = r_pix_valid;
  assign pix_ctr   = r_pix_ctr;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_last  = r_pix_last;
endmodule

// File: tb/tb_mandelbrot_multilane.sv
// Self-checking bench for mandelbrot_multilane. A behavioural model computes
// each pixel's coordinate directly from (x, y), iterates z=z^2+c with integer
// arithmetic and maps the count to a colour; the DUT stream is compared pixel
// by pixel.
module tb_mandelbrot_multilane;
  localparam int BW    = 10;
  localparam int CW    = 7;
  localparam int H     = 3;
  localparam int W     = 6;
  localparam int LANES = 3;
  localparam int FRAC  = BW - 3;
  localparam int XW    = $clog2(W);
  localparam int YW    = $clog2(H);
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run, abort, busy;
  logic [CW-1:0] max_ctr;
  logic [2:0]    ctr_select;
  logic [6:0]    scaling;
  logic [BW-1:0] cr_offset, ci_offset;
`ifdef MANDEL_JULIA_EN
  logic          julia;
  logic [BW-1:0] jc_r, jc_i;
`endif
  logic          pix_valid, pix_ready, pix_last;
  logic [3:0]    pix_ctr;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  int checks = 0;
  int errors = 0;

  // Current frame configuration
  int c_max, c_sel, c_scal, c_cro, c_cio, c_julia, c_jr, c_ji;
  int exp_ctr[$];
  int exp_x[$];
  int exp_y[$];

  always #5 clk = ~clk;

  mandelbrot_multilane #(
    .BITWIDTH(BW), .CTRWIDTH(CW), .HEIGHT(H), .WIDTH(W), .LANES(LANES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .abort      (abort),
    .busy       (busy),
    .max_ctr    (max_ctr),
    .ctr_select (ctr_select),
    .scaling    (scaling),
    .cr_offset  (cr_offset),
    .ci_offset  (ci_offset),
`ifdef MANDEL_JULIA_EN
    .julia      (julia),
    .jc_r       (jc_r),
    .jc_i       (jc_i),
`endif
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_ctr    (pix_ctr),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_last   (pix_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Signed BW-bit wraparound of an integer.
  function automatic int wrapb(input int v);
    int r;
    r = v & ((1 << BW) - 1);
    if (r >= (1 << (BW - 1))) r -= (1 << BW);
    return r;
  endfunction

  function automatic bit fits(input int v);
    return (v >= -(1 << (BW - 1))) && (v <= (1 << (BW - 1)) - 1);
  endfunction

  // Iteration count for one pixel: stop on escape, overflow or the limit.
  function automatic int ref_iter(input int cr, input int ci, input int zr0, input int zi0, input int maxc);
    int zr, zi, n, mag, nr, ni;
    zr = zr0;
    zi = zi0;
    n  = 0;
    forever begin
      mag = zr * zr + zi * zi;
      nr  = ((zr * zr - zi * zi) >>> FRAC) + cr;
      ni  = ((2 * zr * zi) >>> FRAC) + ci;
      if (mag >= (4 << (2 * FRAC))) return n;
      if (!fits(nr) || !fits(ni)) return n;
      if (n == maxc) return n;
      zr = nr;
      zi = ni;
      n++;
    end
  endfunction

  function automatic int ref_colour(input int n, input int sel);
    int sh, k, v;
    if (sel == 7) begin
      if (n == (1 << CW) - 1) return 15;
      k = 0;
      v = n;
      while (v > 1) begin
        v = v / 2;
        k++;
      end
      return k;
    end
    sh = 2 * sel;
    if (sh > CW - 4) sh = CW - 4;
    return (n / (1 << sh)) % 16;
  endfunction

  task automatic build_expected();
    int pr, pi, n, step;
    exp_ctr.delete();
    exp_x.delete();
    exp_y.delete();
    step = c_scal + 1;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        pr = wrapb(c_cro + x * step);
        pi = wrapb(c_cio + y * step);
        if (c_julia != 0) n = ref_iter(wrapb(c_jr), wrapb(c_ji), pr, pi, c_max);
        else              n = ref_iter(pr, pi, 0, 0, c_max);
        exp_ctr.push_back(ref_colour(n, c_sel));
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
    end
  endtask

  task automatic apply_cfg();
    max_ctr    = CW'(c_max);
    ctr_select = 3'(c_sel);
    scaling    = 7'(c_scal);
    cr_offset  = BW'(c_cro);
    ci_offset  = BW'(c_cio);
`ifdef MANDEL_JULIA_EN
    julia      = (c_julia != 0);
    jc_r       = BW'(c_jr);
    jc_i       = BW'(c_ji);
`endif
  endtask

  task automatic set_cfg(input int mx, input int sel, input int scal, input int cro, input int cio);
    c_max   = mx;
    c_sel   = sel;
    c_scal  = scal;
    c_cro   = cro;
    c_cio   = cio;
    c_julia = 0;
    c_jr    = 0;
    c_ji    = 0;
  endtask

  // Runs one frame. abort_after >= 0 aborts once that many pixels are accepted;
  // stall_after >= 0 holds pix_ready low for 50 cycles at that pixel; poke
  // pulses run with altered config mid-frame, which must be ignored.
  task automatic run_frame(input int abort_after, input int stall_after,
                           input bit rand_ready, input bit poke);
    int npix, got, cyc, stall_left;
    bit hold;
    logic [3:0]    h_ctr;
    logic [XW-1:0] h_x;
    logic [YW-1:0] h_y;
    logic          h_last;
    build_expected();
    npix = exp_ctr.size();
    apply_cfg();
    pix_ready = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("busy_after_run", 32'(busy), 1);
    got = 0;
    cyc = 0;
    stall_left = 50;
    hold = 1'b0;
    h_ctr = '0; h_x = '0; h_y = '0; h_last = 1'b0;
    while (got < npix && cyc < BUDGET) begin
      if (got == abort_after) begin
        pix_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(pix_valid), 0);
        return;
      end
      if (poke) begin
        if (cyc == 4) begin
          run = 1'b1;
          max_ctr = ~max_ctr;
          cr_offset = cr_offset + BW'(7);
          scaling = scaling ^ 7'd1;
        end else if (cyc == 5) begin
          run = 1'b0;
          apply_cfg();
        end
      end
      if (stall_after >= 0 && got == stall_after && stall_left > 0) begin
        pix_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        pix_ready = ($urandom_range(0, 3) != 0);
      end else begin
        pix_ready = 1'b1;
      end
      if (hold) begin
        check("hold_valid", 32'(pix_valid), 1);
        check("hold_ctr",   32'(pix_ctr),   32'(h_ctr));
        check("hold_x",     32'(pix_x),     32'(h_x));
        check("hold_y",     32'(pix_y),     32'(h_y));
        check("hold_last",  32'(pix_last),  32'(h_last));
      end
      hold = pix_valid && !pix_ready;
      if (hold) begin
        h_ctr = pix_ctr; h_x = pix_x; h_y = pix_y; h_last = pix_last;
      end
      if (pix_valid && pix_ready) begin
        check($sformatf("pix%0d_x", got),    32'(pix_x),    32'(exp_x[got]));
        check($sformatf("pix%0d_y", got),    32'(pix_y),    32'(exp_y[got]));
        check($sformatf("pix%0d_ctr", got),  32'(pix_ctr),  32'(exp_ctr[got]));
        check($sformatf("pix%0d_last", got), 32'(pix_last), (got == npix - 1) ? 1 : 0);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    run = 1'b0;
    if (got < npix) begin
      check("frame_timeout", 32'(got), 32'(npix));
    end else begin
      check("busy_after_last",  32'(busy),      0);
      check("valid_after_last", 32'(pix_valid), 0);
    end
    pix_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    abort = 1'b0;
    pix_ready = 1'b1;
    set_cfg(0, 0, 0, 0, 0);
    apply_cfg();
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy),      0);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_ctr",   32'(pix_ctr),   0);
    check("rst_x",     32'(pix_x),     0);
    check("rst_y",     32'(pix_y),     0);
    check("rst_last",  32'(pix_last),  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Near-origin frame: every pixel inside the set, reaches the limit.
    set_cfg(3, 0, 0, 0, 0);
    run_frame(-1, -1, 1'b0, 1'b0);

    // -1.5 offset with coarse steps: lanes finish out of order; random ready
    // and an ignored mid-frame run pulse with altered configuration.
    set_cfg(31, 1, 40, -192, -128);
    run_frame(-1, -1, 1'b1, 1'b1);

    // Long backpressure stall mid-frame.
    set_cfg(31, 2, 40, -192, -128);
    run_frame(-1, 5, 1'b0, 1'b0);

    // Colour mapping corners.
    set_cfg(127, 7, 0, 0, 0);     run_frame(-1, -1, 1'b0, 1'b0);
    set_cfg(5,   7, 0, 0, 0);     run_frame(-1, -1, 1'b0, 1'b0);
    set_cfg(0,   7, 40, -192, 0); run_frame(-1, -1, 1'b0, 1'b0);
    set_cfg(127, 6, 0, 0, 0);     run_frame(-1, -1, 1'b0, 1'b0);
    set_cfg(127, 6, 40, -192, -128); run_frame(-1, -1, 1'b1, 1'b0);
    set_cfg(127, 3, 25, -192, -64);  run_frame(-1, -1, 1'b0, 1'b0);

    // Abort after three pixels, then a fresh full frame from (0,0).
    set_cfg(31, 1, 40, -192, -128);
    run_frame(3, -1, 1'b0, 1'b0);
    run_frame(-1, -1, 1'b0, 1'b0);

    // abort together with run in IDLE: abort wins.
    run = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    run = 1'b0;
    abort = 1'b0;
    check("abort_run_busy", 32'(busy), 0);
    @(negedge clk);
    check("abort_run_busy2", 32'(busy), 0);

    // Reset in the middle of a frame.
    apply_cfg();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  32'(busy),      0);
    check("midrst_valid", 32'(pix_valid), 0);
    check("midrst_x",     32'(pix_x),     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(-1, -1, 1'b0, 1'b0);

`ifdef MANDEL_JULIA_EN
    // Julia, c=0: origin stays at zero to the limit, cr=2.0 escapes at once.
    set_cfg(7, 0, 127, 0, 0);
    c_julia = 1;
    run_frame(-1, -1, 1'b0, 1'b0);
    c_julia = 1; c_jr = -100; c_ji = 40; c_scal = 30; c_cro = -160; c_cio = -40; c_max = 63; c_sel = 1;
    run_frame(-1, -1, 1'b1, 1'b0);
`endif

    // Randomised configurations.
    for (int k = 0; k < 4; k++) begin
      set_cfg(int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)));
      run_frame(-1, -1, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
